// File: rtl/ccmp_out_pkg.sv
// Shared types and defaults for the CCMP output buffer.
// Defines the FSM state type, the stored entry layout and default sizing.
package ccmp_out_pkg;

   localparam int CCMP_OUT_DEPTH       = 16;
   localparam int CCMP_OUT_FULL_MARGIN = 2;
   localparam int CCMP_OUT_ENTRY_W     = 9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      DRAIN = 2'd2
   } ccmp_out_state_t;

   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } ccmp_out_entry_t;

endpackage

// File: rtl/ccmp_out_fifo_mem.sv
// DEPTH x 9 storage with one write port and one registered read port.
// Ports: clk/rst_n, we/waddr/wdata write, clr zeroes the read register,
// raddr selects the next head, rdata is the registered head entry.
module ccmp_out_fifo_mem
   import ccmp_out_pkg::*;
#(
   parameter int DEPTH = CCMP_OUT_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  ccmp_out_entry_t wdata,
   input  logic [AW-1:0]   raddr,
   output ccmp_out_entry_t rdata
);

   ccmp_out_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Forward the write so a byte landing on the next head is visible at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   rdata <= '0;
      else if (clr)                 rdata <= '0;
      else if (we && waddr == raddr) rdata <= wdata;
      else                          rdata <= mem[raddr];
   end

endmodule

// File: rtl/ccmp_out_buffer.sv
// Elastic byte buffer after the CCMP core with backpressure and MIC end flag.
// Ports: CCMP byte/valid/last in, consumer pop, head byte/flags, status.
// Optional CCMP_OUT_BYTECNT_EN macro enables the per-frame byte counter.
module ccmp_out_buffer
   import ccmp_out_pkg::*;
#(
   parameter int DEPTH       = CCMP_OUT_DEPTH,
   parameter int FULL_MARGIN = CCMP_OUT_FULL_MARGIN
) (
   input  logic                     macCoreClk,
   input  logic                     nPRst,
   input  logic                     flush_p,
   input  logic [7:0]               ccmpOutDataMux,
   input  logic                     ccmpOutValidMux_p,
   input  logic                     ccmpOutLastMux_p,
   input  logic                     rdEn_p,
   output logic [7:0]               rdData,
   output logic                     rdValid,
   output logic                     rdLast,
   output logic                     txRxBufferFull,
   output logic                     micEnd,
   output logic                     bufIdle,
   output logic                     ovfErr,
   output logic [$clog2(DEPTH):0]   bufCount,
   output logic [15:0]              byteCnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] MARGIN_C = CW'(FULL_MARGIN);

   ccmp_out_state_t state;
   ccmp_out_entry_t head;
   ccmp_out_entry_t wentry;

   logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_next;
   logic [CW-1:0] count, count_next;
   logic [CW-1:0] last_cnt, last_cnt_next;
   logic          wr_req, wr_acc, wr_last, rd_fire, pop_last;

   assign rdValid  = (count != '0);
   assign rd_fire  = rdEn_p & rdValid & ~flush_p;
   assign wr_req   = ccmpOutValidMux_p & ~flush_p;
   // A pop in the same cycle frees the slot, so a full buffer still accepts.
   assign wr_acc   = wr_req & ((count != DEPTH_C) | rd_fire);
   assign wr_last  = wr_acc & ccmpOutLastMux_p;
   assign pop_last = rd_fire & head.last;

   assign wentry.last = ccmpOutLastMux_p;
   assign wentry.data = ccmpOutDataMux;

   always_comb begin
      count_next    = count + CW'(wr_acc) - CW'(rd_fire);
      last_cnt_next = last_cnt + CW'(wr_last) - CW'(pop_last);
      rd_ptr_next   = rd_ptr + AW'(rd_fire);
      if (flush_p) begin
         count_next    = '0;
         last_cnt_next = '0;
         rd_ptr_next   = '0;
      end
   end

   always_ff @(posedge macCoreClk or negedge nPRst) begin
      if (!nPRst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         last_cnt       <= '0;
         txRxBufferFull <= 1'b0;
         micEnd         <= 1'b0;
         ovfErr         <= 1'b0;
      end else begin
         rd_ptr         <= rd_ptr_next;
         count          <= count_next;
         last_cnt       <= last_cnt_next;
         txRxBufferFull <= (DEPTH_C - count_next) <= MARGIN_C;
         // Tracks every last-tagged entry so a second frame keeps micEnd up.
         micEnd         <= (last_cnt_next != '0);
         if (flush_p) begin
            wr_ptr <= '0;
            ovfErr <= 1'b0;
         end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (wr_req && !wr_acc) ovfErr <= 1'b1;
         end
      end
   end

   always_ff @(posedge macCoreClk or negedge nPRst) begin
      if (!nPRst) begin
         state <= IDLE;
      end else if (flush_p) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:    if (wr_acc) state <= wr_last ? DRAIN : FILL;
            FILL:    if (wr_last) state <= DRAIN;
            DRAIN:   if (pop_last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bufIdle  = (state == IDLE) & (count == '0);
   assign bufCount = count;
   assign rdData   = head.data;
   assign rdLast   = head.last;

`ifdef CCMP_OUT_BYTECNT_EN
   logic [15:0] byte_cnt;

   always_ff @(posedge macCoreClk or negedge nPRst) begin
      if (!nPRst) begin
         byte_cnt <= '0;
      end else if (flush_p) begin
         byte_cnt <= '0;
      end else if (wr_acc) begin
         if (state == IDLE)            byte_cnt <= 16'd1;
         else if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
      end
   end

   assign byteCnt = byte_cnt;
`else
   assign byteCnt = 16'h0;
`endif

   ccmp_out_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (macCoreClk),
      .rst_n (nPRst),
      .clr   (flush_p),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wentry),
      .raddr (rd_ptr_next),
      .rdata (head)
   );

endmodule

// File: tb/tb_ccmp_out_buffer.sv
// Directed self-checking bench for ccmp_out_buffer.
// Drives frames, overflow, flush and async reset with hand-derived results.
module tb_ccmp_out_buffer;
   import ccmp_out_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush_p;
   logic [7:0] din;
   logic       vld;
   logic       lst;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_last;
   logic       full;
   logic       mic_end;
   logic       buf_idle;
   logic       ovf;
   logic [4:0] buf_count;
   logic [15:0] byte_cnt;

   int total  = 0;
   int passed = 0;
   logic [7:0] d8;
   logic [31:0] exp_bc;

   always #5 clk = ~clk;

   ccmp_out_buffer dut (
      .macCoreClk        (clk),
      .nPRst             (rst_n),
      .flush_p           (flush_p),
      .ccmpOutDataMux    (din),
      .ccmpOutValidMux_p (vld),
      .ccmpOutLastMux_p  (lst),
      .rdEn_p            (rd_en),
      .rdData            (rd_data),
      .rdValid           (rd_valid),
      .rdLast            (rd_last),
      .txRxBufferFull    (full),
      .micEnd            (mic_end),
      .bufIdle           (buf_idle),
      .ovfErr            (ovf),
      .bufCount          (buf_count),
      .byteCnt           (byte_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         passed++;
   endtask

   task automatic cyc(input logic v, input logic l, input logic [7:0] d,
                      input logic r, input logic f);
      vld = v; lst = l; din = d; rd_en = r; flush_p = f;
      @(posedge clk);
      #1;
      vld = 0; lst = 0; din = 0; rd_en = 0; flush_p = 0;
   endtask

   initial begin
      rst_n = 0; flush_p = 0; din = 0; vld = 0; lst = 0; rd_en = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rdvalid", rd_valid, 0);
      chk("rst_rdlast", rd_last, 0);
      chk("rst_rddata", rd_data, 0);
      chk("rst_full", full, 0);
      chk("rst_micend", mic_end, 0);
      chk("rst_idle", buf_idle, 1);
      chk("rst_ovf", ovf, 0);
      chk("rst_count", buf_count, 0);
      chk("rst_bytecnt", byte_cnt, 0);
      rst_n = 1;
      @(posedge clk); #1;

      // single 5-byte frame
      for (int i = 0; i < 5; i++) begin
         d8 = 8'hA0 + 8'(i);
         cyc(1, i == 4, d8, 0, 0);
      end
      chk("f5_count", buf_count, 5);
      chk("f5_micend", mic_end, 1);
      chk("f5_state", dut.state, DRAIN);
      chk("f5_idle", buf_idle, 0);
      for (int i = 0; i < 5; i++) begin
         d8 = 8'hA0 + 8'(i);
         chk("f5_pop_data", rd_data, d8);
         chk("f5_pop_last", rd_last, i == 4);
         cyc(0, 0, 0, 1, 0);
         if (i == 0) chk("f5_mic_hold", mic_end, 1);
      end
      chk("f5_mic_clr", mic_end, 0);
      chk("f5_idle_end", buf_idle, 1);
      chk("f5_empty", rd_valid, 0);

      // fill to DEPTH, watch backpressure, then overflow
      for (int i = 0; i < 16; i++) begin
         d8 = 8'(i);
         cyc(1, 0, d8, 0, 0);
         chk("fill_full", full, (i + 1) >= 14);
      end
      cyc(1, 0, 8'hEE, 0, 0);
      chk("ovf_count", buf_count, 16);
      chk("ovf_err", ovf, 1);
      chk("ovf_head", rd_data, 8'h00);

      // flush, refill, then write+pop every cycle while full
      cyc(0, 0, 0, 0, 1);
      chk("fl_ovf_clr", ovf, 0);
      chk("fl_count", buf_count, 0);
      for (int i = 0; i < 16; i++) begin
         d8 = 8'(i);
         cyc(1, 0, d8, 0, 0);
      end
      for (int i = 0; i < 20; i++) begin
         d8 = 8'(i);
         chk("thru_data", rd_data, d8);
         d8 = 8'(16 + i);
         cyc(1, 0, d8, 1, 0);
         chk("thru_count", buf_count, 16);
      end
      chk("thru_ovf", ovf, 0);
      chk("thru_head", rd_data, 8'd20);
      chk("thru_full", full, 1);

      // flush mid-frame at count 7 with a write in the flush cycle
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         d8 = 8'h50 + 8'(i);
         cyc(1, i == 2, d8, 0, 0);
      end
      for (int i = 0; i < 4; i++) begin
         d8 = 8'h60 + 8'(i);
         cyc(1, 0, d8, 0, 0);
      end
      chk("mf_count", buf_count, 7);
      chk("mf_micend", mic_end, 1);
      cyc(1, 0, 8'h99, 0, 1);
      chk("mf_fl_count", buf_count, 0);
      chk("mf_fl_valid", rd_valid, 0);
      chk("mf_fl_mic", mic_end, 0);
      chk("mf_fl_state", dut.state, IDLE);
      chk("mf_fl_idle", buf_idle, 1);
      // one-byte frame goes IDLE -> DRAIN directly
      cyc(1, 1, 8'h77, 0, 0);
      chk("one_count", buf_count, 1);
      chk("one_data", rd_data, 8'h77);
      chk("one_last", rd_last, 1);
      chk("one_mic", mic_end, 1);
      chk("one_state", dut.state, DRAIN);

      // async reset while in DRAIN
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         d8 = 8'h30 + 8'(i);
         cyc(1, i == 3, d8, 0, 0);
      end
      chk("ar_state", dut.state, DRAIN);
      #2 rst_n = 0;
      #1;
      chk("ar_valid", rd_valid, 0);
      chk("ar_mic", mic_end, 0);
      chk("ar_count", buf_count, 0);
      chk("ar_idle", buf_idle, 1);
      chk("ar_data", rd_data, 0);
      @(posedge clk); #1;
      rst_n = 1;
      cyc(0, 0, 0, 0, 0);
      chk("ar_rel_valid", rd_valid, 0);
      chk("ar_rel_count", buf_count, 0);

      // 300-byte frame streamed through
`ifdef CCMP_OUT_BYTECNT_EN
      exp_bc = 300;
`else
      exp_bc = 0;
`endif
      cyc(1, 0, 8'd1, 0, 0);
      for (int k = 2; k <= 300; k++) begin
         d8 = 8'(k);
         cyc(1, k == 300, d8, 1, 0);
         if (k == 150) chk("bc_mid", byte_cnt, (exp_bc == 0) ? 0 : 150);
      end
      chk("bc_end", byte_cnt, exp_bc);
      chk("bc_count", buf_count, 1);
      chk("bc_head", rd_data, 8'(300));
      chk("bc_mic", mic_end, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
